// File: rtl/snd_pkg.sv
// Shared constants and status-bit helpers for the sound-CPU command/IRQ latch.
package snd_pkg;

  localparam logic [7:0] EMPTY_BYTE = 8'hFF;

  function automatic int busy_bit(input int nchip);
    return nchip;
  endfunction

  function automatic int pend_bit(input int nchip);
    return nchip + 1;
  endfunction

  // Count must hold the value DEPTH itself, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/snd_irq_latch_ctrl_if.sv
// Command-FIFO bus between the latch controller (master) and snd_cmd_fifo (slave).
interface snd_irq_latch_ctrl_if
  import snd_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = cnt_w(DEPTH);

  logic          push;
  logic          pop;
  logic          flush;
  logic [7:0]    din;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf;

  modport master (output push, pop, flush, din, input head, count, full, empty, ovf);
  modport slave  (input push, pop, flush, din, output head, count, full, empty, ovf);

endinterface

// File: rtl/snd_cmd_fifo.sv
// Main-to-sound command FIFO; a push into a full FIFO either replaces the newest
// entry (OVERWRITE=1) or is dropped and flagged in a sticky ovf bit.
module snd_cmd_fifo
  import snd_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  snd_irq_latch_ctrl_if.slave  fif
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, waddr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, we, do_pop, empty, full;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] dec(input logic [PW-1:0] p);
    return (p == '0) ? LAST : p - 1'b1;
  endfunction

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign do_pop = fif.pop & ~empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    we    = 1'b0;
    waddr = wr_q;
    if (fif.flush) begin
      // Realign read to write so an empty FIFO always has rd == wr.
      rd_d  = wr_q;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (fif.push && full && !do_pop) begin
      if (OVERWRITE) begin
        we    = 1'b1;
        waddr = dec(wr_q);
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      if (fif.push) begin
        we   = 1'b1;
        wr_d = inc(wr_q);
      end
      if (do_pop) rd_d = inc(rd_q);
      cnt_d = cnt_q + CW'(fif.push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[waddr] <= fif.din;
  end

  assign fif.head  = empty ? EMPTY_BYTE : mem_q[rd_q];
  assign fif.count = cnt_q;
  assign fif.full  = full;
  assign fif.empty = empty;
  assign fif.ovf   = ovf_q;

endmodule

// File: rtl/snd_irq_latch_ctrl.sv
// Sound-CPU side latch: FM-chip IRQ edge flags, main-CPU busy flag, command FIFO,
// and a registered active-low interrupt built from the masked status flags.
module snd_irq_latch_ctrl
  import snd_pkg::*;
#(
  parameter int               NCHIP     = 2,
  parameter int               DEPTH     = 4,
  parameter bit               OVERWRITE = 1'b1,
  parameter logic [NCHIP+1:0] IRQ_MASK  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mcode_we,
  input  logic [7:0]       mcode_din,
  output logic             ms,
  input  logic             cmd_rd,
  output logic [7:0]       cmd_dout,
  input  logic             sts_we,
  input  logic [7:0]       sts_din,
  output logic [7:0]       status_dout,
  input  logic [NCHIP-1:0] chip_irq_n,
  output logic             int_n,
  output logic             ovf
);
  localparam int BB = busy_bit(NCHIP);
  localparam int PB = pend_bit(NCHIP);

  snd_irq_latch_ctrl_if #(.DEPTH(DEPTH)) fif ();

  snd_cmd_fifo #(.DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) u_fifo (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  logic [NCHIP-1:0] chip_q, chip_d, line_q;
  logic             busy_q, busy_d, int_n_q;
  logic [PB:0]      ack, flags;

  // A 0 in the ack byte clears the matching flag; set terms are ORed last so they win.
  assign ack    = sts_we ? ~sts_din[PB:0] : '0;
  assign chip_d = (line_q & ~chip_irq_n) | (chip_q & ~ack[NCHIP-1:0]);
  assign busy_d = mcode_we | (busy_q & ~ack[BB]);
  assign flags  = {~fif.empty, busy_q, chip_q};

  assign fif.push  = mcode_we;
  assign fif.pop   = cmd_rd;
  assign fif.flush = ack[PB];
  assign fif.din   = mcode_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      chip_q  <= '0;
      line_q  <= '1;
      busy_q  <= 1'b0;
      int_n_q <= 1'b1;
    end else begin
      chip_q  <= chip_d;
      line_q  <= chip_irq_n;
      busy_q  <= busy_d;
      int_n_q <= ~|(flags & IRQ_MASK);
    end
  end

  always_comb begin
    status_dout       = 8'hFF;
    status_dout[PB:0] = flags;
  end

  assign ms       = busy_q;
  assign int_n    = int_n_q;
  assign cmd_dout = fif.head;
  assign ovf      = fif.ovf;

endmodule

// File: tb/tb_snd_irq_latch_ctrl.sv
// Bench: OVERWRITE=1 and OVERWRITE=0 instances share stimulus; a queue-based
// model predicts every output after each clock.
module tb_snd_irq_latch_ctrl;
  localparam int NCHIP = 2;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst, mcode_we, cmd_rd, sts_we;
  logic [7:0] mcode_din, sts_din;
  logic [1:0] chip_irq_n;

  logic       ms1, int1, ovf1, ms0, int0, ovf0;
  logic [7:0] cmd1, st1, cmd0, st0;

  int checks = 0;
  int errors = 0;
  int stepno = 0;

  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic       m_ovf0 = 1'b0, m_busy = 1'b0, m_int_n = 1'b1;
  logic [1:0] m_chip = 2'b00, m_prev = 2'b11;

  snd_irq_latch_ctrl #(.NCHIP(NCHIP), .DEPTH(DEPTH), .OVERWRITE(1'b1)) dut (
    .clk(clk), .rst(rst), .mcode_we(mcode_we), .mcode_din(mcode_din), .ms(ms1),
    .cmd_rd(cmd_rd), .cmd_dout(cmd1), .sts_we(sts_we), .sts_din(sts_din),
    .status_dout(st1), .chip_irq_n(chip_irq_n), .int_n(int1), .ovf(ovf1));

  snd_irq_latch_ctrl #(.NCHIP(NCHIP), .DEPTH(DEPTH), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .mcode_we(mcode_we), .mcode_din(mcode_din), .ms(ms0),
    .cmd_rd(cmd_rd), .cmd_dout(cmd0), .sts_we(sts_we), .sts_din(sts_din),
    .status_dout(st0), .chip_irq_n(chip_irq_n), .int_n(int0), .ovf(ovf0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%02h expected=%02h", tag, stepno, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] ack;
    logic       fell, pop1, pop0;
    logic [7:0] e1, e0;
    @(posedge clk);
    if (rst) begin
      q1.delete(); q0.delete();
      m_ovf0 = 1'b0; m_busy = 1'b0; m_chip = 2'b00; m_prev = 2'b11; m_int_n = 1'b1;
    end else begin
      m_int_n = !((q1.size() != 0) || m_busy || (m_chip != 2'b00));
      ack = sts_we ? ~sts_din[3:0] : 4'h0;
      for (int i = 0; i < NCHIP; i++) begin
        fell = m_prev[i] && !chip_irq_n[i];
        if (fell) m_chip[i] = 1'b1;
        else if (ack[i]) m_chip[i] = 1'b0;
      end
      if (mcode_we) m_busy = 1'b1;
      else if (ack[2]) m_busy = 1'b0;
      m_prev = chip_irq_n;
      if (ack[3]) begin
        q1.delete(); q0.delete(); m_ovf0 = 1'b0;
      end else begin
        pop1 = cmd_rd && (q1.size() > 0);
        pop0 = cmd_rd && (q0.size() > 0);
        if (mcode_we && q1.size() == DEPTH && !pop1) q1[DEPTH-1] = mcode_din;
        else begin
          if (pop1) void'(q1.pop_front());
          if (mcode_we) q1.push_back(mcode_din);
        end
        if (mcode_we && q0.size() == DEPTH && !pop0) m_ovf0 = 1'b1;
        else begin
          if (pop0) void'(q0.pop_front());
          if (mcode_we) q0.push_back(mcode_din);
        end
      end
    end
    #1;
    stepno++;
    e1 = (q1.size() > 0) ? q1[0] : 8'hFF;
    e0 = (q0.size() > 0) ? q0[0] : 8'hFF;
    chk("cmd_ow",    cmd1, e1);
    chk("cmd_drop",  cmd0, e0);
    chk("sts_ow",    st1, {4'hF, q1.size() != 0, m_busy, m_chip});
    chk("sts_drop",  st0, {4'hF, q0.size() != 0, m_busy, m_chip});
    chk("ms",        {6'd0, ms1, ms0}, {6'd0, m_busy, m_busy});
    chk("int_n",     {6'd0, int1, int0}, {6'd0, m_int_n, m_int_n});
    chk("ovf",       {6'd0, ovf1, ovf0}, {6'd0, 1'b0, m_ovf0});
  endtask

  task automatic drv(input logic r, input logic we, input logic [7:0] d, input logic rd,
                     input logic swe, input logic [7:0] sd, input logic [1:0] ln);
    rst = r; mcode_we = we; mcode_din = d; cmd_rd = rd;
    sts_we = swe; sts_din = sd; chip_irq_n = ln;
    tick();
  endtask

  task automatic go(input logic we, input logic [7:0] d, input logic rd,
                    input logic swe, input logic [7:0] sd, input logic [1:0] ln);
    drv(1'b0, we, d, rd, swe, sd, ln);
  endtask

  logic [7:0] exp_ow   [4] = '{8'h02, 8'h03, 8'h05, 8'hFF};
  logic [7:0] exp_drop [4] = '{8'h02, 8'h03, 8'h04, 8'hFF};
  logic [7:0] exp47_ow   [4] = '{8'hA3, 8'hA4, 8'hC6, 8'hFF};
  logic [7:0] exp47_drop [4] = '{8'hA3, 8'hA4, 8'hB5, 8'hFF};

  initial begin
    rst = 1'b1; mcode_we = 1'b0; mcode_din = 8'h00; cmd_rd = 1'b0;
    sts_we = 1'b0; sts_din = 8'hFF; chip_irq_n = 2'b11;

    // Reset with strobes asserted: they must be ignored.
    drv(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 8'h00, 2'b11);
    drv(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 2'b11);
    chk("rst_status", st1, 8'hF0);
    chk("rst_cmd", cmd1, 8'hFF);
    chk("rst_int_ms", {6'd0, int1, ms1}, 8'h02);

    // Two commands, two reads, then ack busy.
    go(1'b1, 8'h12, 1'b0, 1'b0, 8'hFF, 2'b11);
    chk("push12_cmd", cmd1, 8'h12);
    chk("push12_sts", st1, 8'hFC);
    go(1'b1, 8'h34, 1'b0, 1'b0, 8'hFF, 2'b11);
    go(1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 2'b11);
    chk("pop1_cmd", cmd1, 8'h34);
    go(1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 2'b11);
    chk("pop2_cmd", cmd1, 8'hFF);
    chk("pop2_sts", st1, 8'hF4);
    go(1'b0, 8'h00, 1'b0, 1'b1, 8'hFB, 2'b11);
    chk("ackbusy_ms", {7'd0, ms1}, 8'h00);
    go(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 2'b11);

    // Chip 1 IRQ pulse, then ack.
    go(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 2'b01);
    chk("irq1_sts", st1, 8'hF2);
    go(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 2'b11);
    chk("irq1_int", {7'd0, int1}, 8'h00);
    go(1'b0, 8'h00, 1'b0, 1'b1, 8'hFD, 2'b11);
    chk("ack1_sts", st1, 8'hF0);
    go(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 2'b11);
    chk("ack1_int", {7'd0, int1}, 8'h01);

    // Set wins over same-cycle ack; a held-low line does not re-set.
    go(1'b0, 8'h00, 1'b0, 1'b1, 8'hFE, 2'b10);
    chk("setwins", st1, 8'hF1);
    go(1'b0, 8'h00, 1'b0, 1'b1, 8'hFE, 2'b10);
    go(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 2'b10);
    chk("heldlow", st1, 8'hF0);
    go(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 2'b11);

    // Five pushes into a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) go(1'b1, 8'(i), 1'b0, 1'b0, 8'hFF, 2'b11);
    chk("ovf_drop", {7'd0, ovf0}, 8'h01);
    chk("ovf_ow", {7'd0, ovf1}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      go(1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 2'b11);
      chk("ovpop_ow", cmd1, exp_ow[i]);
      chk("ovpop_drop", cmd0, exp_drop[i]);
    end
    go(1'b0, 8'h00, 1'b0, 1'b1, 8'hF7, 2'b11);
    chk("flush_ovf", {7'd0, ovf0}, 8'h00);

    // Full FIFO: simultaneous push+pop keeps it full.
    for (int i = 1; i <= 4; i++) go(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 8'hFF, 2'b11);
    go(1'b1, 8'hB5, 1'b1, 1'b0, 8'hFF, 2'b11);
    chk("pp_cmd", cmd1, 8'hA2);
    go(1'b1, 8'hC6, 1'b0, 1'b0, 8'hFF, 2'b11);
    chk("pp_stillfull", {7'd0, ovf0}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      go(1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 2'b11);
      chk("pppop_ow", cmd1, exp47_ow[i]);
      chk("pppop_drop", cmd0, exp47_drop[i]);
    end
    go(1'b0, 8'h00, 1'b0, 1'b1, 8'hF7, 2'b11);

    // Reset with queued entries and all flags set.
    go(1'b1, 8'h11, 1'b0, 1'b0, 8'hFF, 2'b11);
    go(1'b1, 8'h22, 1'b0, 1'b0, 8'hFF, 2'b11);
    go(1'b1, 8'h33, 1'b0, 1'b0, 8'hFF, 2'b00);
    chk("prerst_sts", st1, 8'hFF);
    drv(1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'hFF, 2'b00);
    chk("midrst_sts", st1, 8'hF0);
    chk("midrst_cmd", cmd1, 8'hFF);
    chk("midrst_int_ms", {6'd0, int1, ms1}, 8'h02);
    go(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 2'b00);
    go(1'b0, 8'h00, 1'b0, 1'b1, 8'hFC, 2'b11);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drv($urandom_range(0, 99) < 2,
          $urandom_range(0, 9) < 4, 8'($urandom),
          $urandom_range(0, 9) < 4,
          $urandom_range(0, 9) < 2,
          8'($urandom) | (($urandom_range(0, 3) != 0) ? 8'h08 : 8'h00),
          2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snd_irq_latch_ctrl.md
SND_IRQ_LATCH_CTRL -- requirements
Module: snd_irq_latch_ctrl

Interface
REQ-001 SHALL have parameter NCHIP, default 2: number of FM chip IRQ sources; legal range 1..4.
REQ-002 SHALL have parameter DEPTH, default 4: command FIFO entries; a power of 2 in 1..16.
REQ-003 SHALL have parameter OVERWRITE, default 1: on push to a full FIFO, 1 overwrites the newest entry and 0 drops the push.
REQ-004 SHALL have parameter IRQ_MASK, width NCHIP+2, default all ones: per-status-bit contribution to int_n.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-006 clk  in  1  system clock, 53.6 MHz.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 mcode_we  in  1  main-CPU command write strobe, one clk wide.
REQ-009 mcode_din  in  8  command byte.
REQ-010 ms  out  1  sound-CPU busy flag, returned to the main CPU.
REQ-011 cmd_rd  in  1  sound-CPU command read strobe, one clk wide; pops the FIFO.
REQ-012 cmd_dout  out  8  FIFO head; 8'hFF when the FIFO is empty.
REQ-013 sts_we  in  1  status/ack write strobe, one clk wide.
REQ-014 sts_din  in  8  ack byte.
REQ-015 status_dout  out  8  status byte.
REQ-016 chip_irq_n  in  NCHIP  active-low IRQ lines from the FM chips.
REQ-017 int_n  out  1  active-low Z80 interrupt.
REQ-018 ovf  out  1  sticky overflow flag; only used when OVERWRITE=0.

Function
REQ-019 Chip flag i SHALL set on the clk after a falling edge of chip_irq_n[i], detected against a registered copy of the line; a line held low SHALL NOT re-set a cleared flag.
REQ-020 The busy flag SHALL set on the clk after mcode_we; ms SHALL equal the busy flag.
REQ-021 The pending flag SHALL be 1 exactly when the FIFO is not empty.
REQ-022 Status layout: bits[NCHIP-1:0] are the chip flags, bit NCHIP is busy, bit NCHIP+1 is pending, and the remaining bits read 1.
REQ-023 An sts_we with sts_din bit k = 0 SHALL clear flag k (chip flag or busy); a 1 SHALL leave it unchanged.
REQ-024 Writing 0 to bit NCHIP+1 with sts_we SHALL flush the FIFO (count := 0) and clear ovf.
REQ-025 When a flag set and an ack clear for the same flag occur in the same clk, the set SHALL win.
REQ-026 int_n SHALL be the registered value of ~|(status flags & IRQ_MASK), updated one clk after the flag change.
REQ-027 A push SHALL make the data readable on cmd_dout on the next clk.
REQ-028 A pop SHALL advance cmd_dout to the next entry on the next clk.
REQ-029 Push and pop in the same clk with count>0 SHALL both take effect, leaving count unchanged.
REQ-030 When full, a push with a simultaneous pop SHALL be accepted normally.
REQ-031 A pop on an empty FIFO SHALL be ignored.
REQ-032 A push to a full FIFO with no pop: OVERWRITE=1 replaces the newest entry; OVERWRITE=0 drops the byte and sets ovf.
REQ-033 Pointers SHALL wrap modulo DEPTH.
REQ-034 Count SHALL be log2(DEPTH)+1 bits wide.
REQ-035 With DEPTH=1 and OVERWRITE=1 the block SHALL behave as a single command latch.
REQ-036 status_dout and cmd_dout SHALL reflect register state only; read strobes SHALL have no side effect other than the cmd_rd pop.

Reset
REQ-037 While rst=1, all flags, ovf, count and pointers SHALL be 0.
REQ-038 While rst=1, ms=0, int_n=1 and cmd_dout=8'hFF.
REQ-039 While rst=1, status_dout SHALL have its flag bits at 0 and its unused bits at 1.
REQ-040 The registered copies of chip_irq_n SHALL reset to 1.
REQ-041 A reset asserted mid-transfer SHALL discard FIFO contents; strobes during reset SHALL be ignored.

Structure
REQ-042 snd_pkg SHALL hold the status bit-index functions (busy = NCHIP, pending = NCHIP+1) and the EMPTY_BYTE = 8'hFF constant.
REQ-043 The FIFO SHALL be a sub-module snd_cmd_fifo (parameters DEPTH and OVERWRITE) with push, pop, flush, head, count, full, empty and ovf.

Verification
REQ-044 Push 8'h12 then 8'h34, then pop twice -> cmd_dout 12 then 34 then FF; pending goes 1 then 0; ms=1 until sts_din 8'hFB (NCHIP=2).
REQ-045 Pulse chip_irq_n[1] low for 1 clk -> status bit1=1 and int_n=0; write sts_din 8'hFD -> bit1=0 and int_n=1 one clk later.
REQ-046 DEPTH=4, OVERWRITE=0: 5 pushes 01..05 -> ovf=1 and pops return 01..04; with OVERWRITE=1 the pops return 01,02,03,05.
REQ-047 Full FIFO with simultaneous push and pop -> count stays 4 and the new byte is the last popped.
REQ-048 Falling edge of chip_irq_n[0] in the same clk as sts_din 8'hFE -> flag0 remains 1.
REQ-049 rst asserted with 3 entries queued and all flags set -> cmd_dout=FF, status=8'hF0, int_n=1 and ms=0 on the next clk.
